// File: rtl/pattern_game_ctrl.sv
// Sequencer for the LED pattern-memory game: generates an LFSR pattern, replays
// the first `level` entries on the LEDs, then checks encoded button presses.
module pattern_game_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int SHOW_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 16,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    seed,
  input  logic          key_valid,
  input  logic [1:0]    key_code,
  output logic          input_en,
  output logic [3:0]    led,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          win,
  output logic          lose
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = $clog2(SHOW_CYCLES + GAP_CYCLES);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [IW-1:0] idx;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] idx_inc;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          replay;
  logic [1:0]    mem [MAX_LEN];

  assign idx_inc = idx + 1'b1;

  function automatic logic [3:0] onehot(input logic [1:0] code);
    case (code)
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0010;
      2'b11:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Pattern memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && state == GEN)
      mem[idx] <= lfsr[1:0];
  end

  // last_idx shadows level-1 so index comparisons stay in one width.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      led      <= 4'b0000;
      input_en <= 1'b0;
      level    <= '0;
      busy     <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      lfsr     <= 8'h01;
      idx      <= '0;
      last_idx <= '0;
      cnt      <= '0;
      timer    <= '0;
      replay   <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state    <= GEN;
            lfsr     <= (seed == 8'h00) ? 8'h01 : seed;
            idx      <= '0;
            last_idx <= '0;
            level    <= LW'(1);
            busy     <= 1'b1;
            win      <= 1'b0;
            lose     <= 1'b0;
            led      <= 4'b0000;
            input_en <= 1'b0;
            replay   <= 1'b0;
          end
        end
        GEN: begin
          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          if (idx == IW'(MAX_LEN - 1)) begin
            state <= SHOW_ON;
            idx   <= '0;
            cnt   <= '0;
            led   <= onehot(mem[0]);
          end else begin
            idx <= idx_inc;
          end
        end
        SHOW_ON: begin
          if (cnt == CW'(SHOW_CYCLES - 1)) begin
            state <= SHOW_OFF;
            cnt   <= '0;
            led   <= 4'b0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // After a level-up the gap is followed by a replay from entry 0.
        SHOW_OFF: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (replay) begin
              replay <= 1'b0;
              idx    <= '0;
              state  <= SHOW_ON;
              led    <= onehot(mem[0]);
            end else if (idx == last_idx) begin
              state    <= WAIT_IN;
              idx      <= '0;
              timer    <= '0;
              input_en <= 1'b1;
            end else begin
              idx   <= idx_inc;
              state <= SHOW_ON;
              led   <= onehot(mem[idx_inc]);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IN: begin
          if (key_valid) begin
            if (key_code != mem[idx]) begin
              state    <= LOSE;
              lose     <= 1'b1;
              busy     <= 1'b0;
              input_en <= 1'b0;
            end else if (idx != last_idx) begin
              idx   <= idx_inc;
              timer <= '0;
            end else if (last_idx == IW'(MAX_LEN - 1)) begin
              state    <= WIN;
              win      <= 1'b1;
              busy     <= 1'b0;
              input_en <= 1'b0;
            end else begin
              state    <= SHOW_OFF;
              level    <= level + 1'b1;
              last_idx <= last_idx + 1'b1;
              idx      <= '0;
              cnt      <= '0;
              replay   <= 1'b1;
              input_en <= 1'b0;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state    <= LOSE;
            lose     <= 1'b1;
            busy     <= 1'b0;
            input_en <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_game_ctrl.sv
// Directed self-checking bench for pattern_game_ctrl; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_pattern_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'b00;
  logic       input_en;
  logic [3:0] led;
  logic [3:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  int tests = 0;
  int fails = 0;

  // Pattern for seed 8'h01, worked out by hand from the LFSR recurrence.
  logic [1:0] pat [8] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b10};

  always #5 clk = ~clk;

  pattern_game_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .key_valid(key_valid), .key_code(key_code),
    .input_en(input_en), .led(led), .level(level),
    .busy(busy), .win(win), .lose(lose)
  );

  function automatic logic [3:0] led_of(input logic [1:0] c);
    case (c)
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0010;
      2'b11:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] s);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_input_en(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (input_en) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL %s: input_en never rose within 400 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(2);
    tests++;
    if ({led, input_en, level, busy, win, lose} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got led=%b en=%b lvl=%0d busy=%b win=%b lose=%b, want all 0",
               led, input_en, level, busy, win, lose);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    do_reset();
    do_start(8'h01);
    tests++;
    if (busy !== 1'b1 || level !== 4'd1 || led !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL gen_entry: got busy=%b lvl=%0d led=%b, want 1 1 0000", busy, level, led);
    end
    wait_cycles(7);
    tests++;
    if (led !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL led_early: got %b, want 0000", led);
    end
    wait_cycles(1);
    tests++;
    if (led !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL led_first: got %b, want 0001", led);
    end
    wait_cycles(3);
    tests++;
    if (led !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL led_hold: got %b, want 0001", led);
    end
    wait_cycles(1);
    tests++;
    if (led !== 4'b0000 || input_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL led_gap: got led=%b en=%b, want 0000 0", led, input_en);
    end
    wait_cycles(1);
    tests++;
    if (led !== 4'b0000 || input_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL gap_end: got led=%b en=%b, want 0000 0", led, input_en);
    end
    wait_cycles(1);
    tests++;
    if (input_en !== 1'b1 || led !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL wait_entry: got en=%b led=%b, want 1 0000", input_en, led);
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    do_start(8'h01);
    wait_cycles(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (led !== 4'b0000 || busy !== 1'b0 || level !== 4'd0 || input_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_show: got led=%b busy=%b lvl=%0d en=%b, want 0000 0 0 0",
               led, busy, level, input_en);
    end
    do_start(8'h01);
    wait_cycles(8);
    tests++;
    if (led !== 4'b0001 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL restart_after_reset: got led=%b busy=%b, want 0001 1", led, busy);
    end
  endtask

  task automatic test_seed_zero();
    do_reset();
    do_start(8'h00);
    wait_cycles(8);
    tests++;
    if (led !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL seed_zero: got led=%b, want 0001", led);
    end
  endtask

  task automatic test_level_up();
    do_reset();
    do_start(8'h01);
    wait_input_en("level1_wait");
    press(2'b01);
    tests++;
    if (level !== 4'd2 || input_en !== 1'b0 || led !== 4'b0000 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL level_up: got lvl=%0d en=%b led=%b busy=%b, want 2 0 0000 1",
               level, input_en, led, busy);
    end
    wait_cycles(2);
    tests++;
    if (led !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL replay_first: got %b, want 0001", led);
    end
    wait_cycles(6);
    tests++;
    if (led !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL replay_second: got %b, want 0010", led);
    end
    wait_input_en("level2_wait");
    press(2'b01);
    tests++;
    if (level !== 4'd2 || input_en !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_sequence: got lvl=%0d en=%b, want 2 1", level, input_en);
    end
    press(2'b10);
    tests++;
    if (level !== 4'd3 || lose !== 1'b0) begin
      fails++;
      $display("[TB] FAIL level3: got lvl=%0d lose=%b, want 3 0", level, lose);
    end
  endtask

  task automatic test_wrong_key();
    do_reset();
    do_start(8'h01);
    wait_input_en("wrong_wait");
    press(2'b10);
    tests++;
    if (lose !== 1'b1 || input_en !== 1'b0 || level !== 4'd1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrong_key: got lose=%b en=%b lvl=%0d busy=%b, want 1 0 1 0",
               lose, input_en, level, busy);
    end
    press(2'b01);
    tests++;
    if (lose !== 1'b1 || level !== 4'd1) begin
      fails++;
      $display("[TB] FAIL key_in_lose: got lose=%b lvl=%0d, want 1 1", lose, level);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start(8'h01);
    wait_input_en("timeout_wait");
    wait_cycles(14);
    tests++;
    if (lose !== 1'b0 || input_en !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_early: got lose=%b en=%b, want 0 1", lose, input_en);
    end
    wait_cycles(2);
    tests++;
    if (lose !== 1'b1 || input_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_lose: got lose=%b en=%b, want 1 0", lose, input_en);
    end
    do_start(8'h01);
    wait_input_en("timeout_wait2");
    wait_cycles(14);
    press(2'b01);
    tests++;
    if (lose !== 1'b0 || level !== 4'd2) begin
      fails++;
      $display("[TB] FAIL late_press: got lose=%b lvl=%0d, want 0 2", lose, level);
    end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    do_start(8'h01);
    start     = 1'b1;
    seed      = 8'h56;
    key_valid = 1'b1;
    key_code  = 2'b11;
    @(negedge clk);
    start     = 1'b0;
    key_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || level !== 4'd1 || lose !== 1'b0) begin
      fails++;
      $display("[TB] FAIL busy_ignore: got busy=%b lvl=%0d lose=%b, want 1 1 0", busy, level, lose);
    end
    wait_input_en("busy_wait");
    press(2'b01);
    tests++;
    if (level !== 4'd2 || lose !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pattern_kept: got lvl=%0d lose=%b, want 2 0", level, lose);
    end
  endtask

  task automatic test_win();
    do_reset();
    do_start(8'h01);
    for (int lv = 1; lv <= 8; lv++) begin
      wait_input_en("win_wait");
      tests++;
      if (level !== 4'(lv)) begin
        fails++;
        $display("[TB] FAIL win_level: got %0d, want %0d", level, lv);
      end
      for (int i = 0; i < lv; i++) press(pat[i]);
      if (lv == 7) begin
        wait_cycles(2);
        for (int i = 0; i < 8; i++) begin
          tests++;
          if (led !== led_of(pat[i])) begin
            fails++;
            $display("[TB] FAIL replay8_%0d: got %b, want %b", i, led, led_of(pat[i]));
          end
          wait_cycles(6);
        end
      end
    end
    tests++;
    if (win !== 1'b1 || level !== 4'd8 || busy !== 1'b0 || input_en !== 1'b0 || led !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL win: got win=%b lvl=%0d busy=%b en=%b led=%b, want 1 8 0 0 0000",
               win, level, busy, input_en, led);
    end
    press(2'b00);
    tests++;
    if (win !== 1'b1 || level !== 4'd8) begin
      fails++;
      $display("[TB] FAIL win_hold: got win=%b lvl=%0d, want 1 8", win, level);
    end
    do_start(8'h01);
    tests++;
    if (win !== 1'b0 || busy !== 1'b1 || level !== 4'd1) begin
      fails++;
      $display("[TB] FAIL restart_from_win: got win=%b busy=%b lvl=%0d, want 0 1 1", win, busy, level);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_reset_mid_show();
    test_seed_zero();
    test_level_up();
    test_wrong_key();
    test_timeout();
    test_busy_ignore();
    test_win();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
